// File: rtl/equalizer_gain_scheduler_if.sv
// Host write channel for equalizer_gain_scheduler.
//   wr_valid : host request to update one band's target gain
//   wr_ready : scheduler accepts (only while no ramp scan is in flight)
//   wr_band  : band index, 0 = lpf_1000hz ... 7 = hpf_7000hz
//   wr_gain  : new signed 8.2 target gain
// master = host/config side, slave = scheduler side.
interface equalizer_gain_scheduler_if #(
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int GAIN_BITS         = 8
);
    localparam int BAND_BITS = $clog2(NUMBER_OF_FILTERS);

    logic                 wr_valid;
    logic                 wr_ready;
    logic [BAND_BITS-1:0] wr_band;
    logic [GAIN_BITS-1:0] wr_gain;

    modport master (output wr_valid, output wr_band, output wr_gain, input wr_ready);
    modport slave  (input wr_valid, input wr_band, input wr_gain, output wr_ready);
endinterface

// File: rtl/equalizer_gain_scheduler.sv
// Gain scheduler for the 8-band equalizer.
// Generates the sample-rate clk_enable strobe, stores host-written target
// gains, and once per sample ramps a shadow set of current gains toward the
// targets by at most STEP LSBs, then commits all bands to amplifier_gains in
// one cycle so the equalizer never sees a partially updated set.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   run               : enables the sample counter
//   mute              : forces every band's effective target to 0
//   wr_if (slave)     : host target-gain write channel
//   clk_enable        : one-cycle sample strobe
//   amplifier_enable  : run delayed by one cycle
//   amplifier_gains   : packed live gains, band b at [(b+1)*GAIN_BITS-1 -: GAIN_BITS]
//   ramp_busy         : high while scanning or committing
module equalizer_gain_scheduler #(
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int GAIN_BITS         = 8,
    parameter int SAMPLE_DIV        = 64,
    parameter int STEP              = 1,
    parameter int DEFAULT_GAIN      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   run,
    input  logic                                   mute,
    equalizer_gain_scheduler_if.slave              wr_if,
    output logic                                   clk_enable,
    output logic                                   amplifier_enable,
    output logic                                   ramp_busy,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains
);
    localparam int CNT_BITS  = $clog2(SAMPLE_DIV);
    localparam int BAND_BITS = $clog2(NUMBER_OF_FILTERS);

    localparam logic [CNT_BITS-1:0]        CNT_LAST  = CNT_BITS'(SAMPLE_DIV - 1);
    localparam logic [BAND_BITS-1:0]       BAND_LAST = BAND_BITS'(NUMBER_OF_FILTERS - 1);
    localparam logic [GAIN_BITS-1:0]       DEFAULT_G = GAIN_BITS'(DEFAULT_GAIN);
    localparam logic [GAIN_BITS-1:0]       STEP_G    = GAIN_BITS'(STEP);
    localparam logic signed [GAIN_BITS:0]  STEP_W    = (GAIN_BITS + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_e;

    state_e                               state_q, state_d;
    logic [CNT_BITS-1:0]                  cnt_q, cnt_d;
    logic [BAND_BITS-1:0]                 band_q, band_d;
    logic                                 clk_enable_q, clk_enable_d;
    logic                                 amp_en_q, amp_en_d;
    logic                                 out_of_reset_q, out_of_reset_d;
    logic [GAIN_BITS-1:0]                 target_q [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0]                 target_d [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0]                 cur_q    [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0]                 cur_d    [NUMBER_OF_FILTERS];
    logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gains_q, gains_d;

    logic                                 wr_fire;
    logic [GAIN_BITS-1:0]                 eff;
    logic [GAIN_BITS-1:0]                 cur_sel;
    logic signed [GAIN_BITS:0]            diff;

    // Targets are frozen while a scan is in flight, and the channel stays
    // closed until the first edge after reset releases.
    assign wr_if.wr_ready = out_of_reset_q && (state_q == ST_IDLE);
    assign wr_fire        = wr_if.wr_valid && wr_if.wr_ready;

    // Sign-extend both operands by one bit so the difference of two extreme
    // gains cannot overflow.
    assign eff     = mute ? '0 : target_q[band_q];
    assign cur_sel = cur_q[band_q];
    assign diff    = $signed({eff[GAIN_BITS-1], eff}) - $signed({cur_sel[GAIN_BITS-1], cur_sel});

    always_comb begin
        cnt_d          = '0;
        if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        clk_enable_d   = (cnt_q == CNT_LAST);
        amp_en_d       = run;
        out_of_reset_d = 1'b1;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        state_d  = state_q;
        band_d   = band_q;
        target_d = target_q;
        cur_d    = cur_q;
        gains_d  = gains_q;

        if (wr_fire) begin
            target_d[wr_if.wr_band] = wr_if.wr_gain;
        end

        case (state_q)
            ST_IDLE: begin
                if (clk_enable_q) begin
                    state_d = ST_SCAN;
                    band_d  = '0;
                end
            end
            ST_SCAN: begin
                // Step toward the effective target; a gap within STEP snaps
                // exactly onto it, so the result never passes the target.
                if (diff > STEP_W) begin
                    cur_d[band_q] = cur_sel + STEP_G;
                end else if (diff < -STEP_W) begin
                    cur_d[band_q] = cur_sel - STEP_G;
                end else begin
                    cur_d[band_q] = eff;
                end
                if (band_q == BAND_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    band_d = band_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                for (int b = 0; b < NUMBER_OF_FILTERS; b++) begin
                    gains_d[b*GAIN_BITS +: GAIN_BITS] = cur_q[b];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the gain files are reset explicitly, because every stored and
    // live gain must come up at DEFAULT_GAIN, not as RAM contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            band_q         <= '0;
            clk_enable_q   <= 1'b0;
            amp_en_q       <= 1'b0;
            out_of_reset_q <= 1'b0;
            gains_q        <= {NUMBER_OF_FILTERS{DEFAULT_G}};
            for (int b = 0; b < NUMBER_OF_FILTERS; b++) begin
                target_q[b] <= DEFAULT_G;
                cur_q[b]    <= DEFAULT_G;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            band_q         <= band_d;
            clk_enable_q   <= clk_enable_d;
            amp_en_q       <= amp_en_d;
            out_of_reset_q <= out_of_reset_d;
            gains_q        <= gains_d;
            target_q       <= target_d;
            cur_q          <= cur_d;
        end
    end

    assign clk_enable       = clk_enable_q;
    assign amplifier_enable = amp_en_q;
    assign ramp_busy        = (state_q != ST_IDLE);
    assign amplifier_gains  = gains_q;
endmodule

// File: tb/tb_equalizer_gain_scheduler.sv
// Self-checking bench for equalizer_gain_scheduler. Two instances share the
// clock and control inputs: dut1 uses STEP=1, dut3 uses STEP=3. Expected
// committed gain vectors are queued when a write or mode change is driven and
// popped when the following commit becomes visible.
module tb_equalizer_gain_scheduler;
    logic        clk;
    logic        rst_n;
    logic        run;
    logic        mute;
    logic        ce1, ae1, rb1;
    logic        ce3, ae3, rb3;
    logic [63:0] g1, g3;

    equalizer_gain_scheduler_if wif1 ();
    equalizer_gain_scheduler_if wif3 ();

    equalizer_gain_scheduler #(.STEP(1)) dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .mute             (mute),
        .wr_if            (wif1.slave),
        .clk_enable       (ce1),
        .amplifier_enable (ae1),
        .ramp_busy        (rb1),
        .amplifier_gains  (g1)
    );

    equalizer_gain_scheduler #(.STEP(3)) dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .mute             (mute),
        .wr_if            (wif3.slave),
        .clk_enable       (ce3),
        .amplifier_enable (ae3),
        .ramp_busy        (rb3),
        .amplifier_gains  (g3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp_last [2];

    function automatic logic [63:0] all_gain(input logic [7:0] v);
        return {8{v}};
    endfunction

    function automatic logic [63:0] with_band(input logic [63:0] base, input int b, input logic [7:0] v);
        logic [63:0] r;
        r = base;
        r[b*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [63:0] gains_of(input int w);
        return (w == 0) ? g1 : g3;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? rb1 : rb3;
    endfunction

    function automatic logic ce_of(input int w);
        return (w == 0) ? ce1 : ce3;
    endfunction

    function automatic logic ready_of(input int w);
        return (w == 0) ? wif1.wr_ready : wif3.wr_ready;
    endfunction

    task automatic drive_wr(input int w, input logic v, input logic [2:0] band, input logic [7:0] gain);
        if (w == 0) begin
            wif1.wr_valid = v;
            wif1.wr_band  = band;
            wif1.wr_gain  = gain;
        end else begin
            wif3.wr_valid = v;
            wif3.wr_band  = band;
            wif3.wr_gain  = gain;
        end
    endtask

    // Hold a write until it is accepted; called from a negedge.
    task automatic do_write(input int w, input logic [2:0] band, input logic [7:0] gain);
        bit accepted;
        accepted = 1'b0;
        drive_wr(w, 1'b1, band, gain);
        for (int i = 0; i < 100; i++) begin
            if (ready_of(w)) begin
                accepted = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        drive_wr(w, 1'b0, 3'd0, 8'h00);
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL write_accept dut%0d band %0d: got no wr_ready expected accept", w, band);
        end
    endtask

    task automatic wait_strobe(input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ce_of(w) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Follows one strobe through scan and commit; ends at strobe+10.
    task automatic check_commit(input int w, input string name);
        bit          ok;
        logic [63:0] exp;
        wait_strobe(w, ok);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s strobe: got no clk_enable expected one within 200 cycles", name);
            if (exp_q.size() > 0) exp_q.delete(0);
            return;
        end
        @(negedge clk);
        total++;
        if (busy_of(w) !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_rise: got %b expected 1", name, busy_of(w));
        end
        repeat (8) @(negedge clk);
        total++;
        if (busy_of(w) !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_commit: got %b expected 1", name, busy_of(w));
        end
        total++;
        if (ready_of(w) !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_commit: got %b expected 0", name, ready_of(w));
        end
        total++;
        if (gains_of(w) !== exp_last[w]) begin
            bad++;
            $display("FAIL %s pre_commit_gains: got %h expected %h", name, gains_of(w), exp_last[w]);
        end
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
            return;
        end
        exp = exp_q.pop_front();
        if (gains_of(w) !== exp) begin
            bad++;
            $display("FAIL %s gains: got %h expected %h", name, gains_of(w), exp);
        end
        total++;
        if (busy_of(w) !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_fall: got %b expected 0", name, busy_of(w));
        end
        exp_last[w] = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        mute  = 1'b0;
        drive_wr(0, 1'b0, 3'd0, 8'h00);
        drive_wr(1, 1'b0, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        total++;
        if (g1 !== all_gain(8'h04)) begin bad++; $display("FAIL rst_gains1: got %h expected %h", g1, all_gain(8'h04)); end
        total++;
        if (g3 !== all_gain(8'h04)) begin bad++; $display("FAIL rst_gains3: got %h expected %h", g3, all_gain(8'h04)); end
        total++;
        if (wif1.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", wif1.wr_ready); end
        total++;
        if ({ce1, ae1, rb1} !== 3'b000) begin bad++; $display("FAIL rst_ctrl: got %b expected 000", {ce1, ae1, rb1}); end
        rst_n = 1'b1;
        for (int n = 1; n <= 128; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total++;
                if (wif1.wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst: got %b expected 1", wif1.wr_ready); end
                total++;
                if (ae1 !== 1'b1) begin bad++; $display("FAIL amp_enable: got %b expected 1", ae1); end
            end
            total++;
            if (ce1 !== ((n == 64) || (n == 128))) begin
                bad++;
                $display("FAIL strobe_cycle_%0d: got %b expected %b", n, ce1, (n == 64) || (n == 128));
            end
        end
        repeat (10) @(negedge clk);
        total++;
        if (g1 !== all_gain(8'h04)) begin bad++; $display("FAIL settled_commit: got %h expected %h", g1, all_gain(8'h04)); end
        exp_last[0] = all_gain(8'h04);
        exp_last[1] = all_gain(8'h04);
    endtask

    task automatic test_up_ramp();
        // The second write to the same band overwrites the first.
        do_write(0, 3'd3, 8'h20);
        do_write(0, 3'd3, 8'h08);
        exp_q.push_back(with_band(all_gain(8'h04), 3, 8'h05));
        exp_q.push_back(with_band(all_gain(8'h04), 3, 8'h06));
        exp_q.push_back(with_band(all_gain(8'h04), 3, 8'h07));
        exp_q.push_back(with_band(all_gain(8'h04), 3, 8'h08));
        exp_q.push_back(with_band(all_gain(8'h04), 3, 8'h08));
        for (int i = 0; i < 5; i++) check_commit(0, "up_ramp");
    endtask

    task automatic test_clamp();
        do_write(1, 3'd0, 8'hF8);
        exp_q.push_back(with_band(all_gain(8'h04), 0, 8'h01));
        exp_q.push_back(with_band(all_gain(8'h04), 0, 8'hFE));
        exp_q.push_back(with_band(all_gain(8'h04), 0, 8'hFB));
        exp_q.push_back(with_band(all_gain(8'h04), 0, 8'hF8));
        exp_q.push_back(with_band(all_gain(8'h04), 0, 8'hF8));
        for (int i = 0; i < 5; i++) check_commit(1, "clamp_step3");
    endtask

    task automatic test_mute();
        logic [7:0] up_others [6];
        up_others = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04};
        // Bring band 3 back to 4 so every band starts level.
        do_write(0, 3'd3, 8'h04);
        for (int v = 7; v >= 4; v--) exp_q.push_back(with_band(all_gain(8'h04), 3, 8'(v)));
        for (int i = 0; i < 4; i++) check_commit(0, "down_ramp");
        mute = 1'b1;
        // Stored while muted; must surface only after unmute.
        do_write(0, 3'd2, 8'h06);
        for (int v = 3; v >= 0; v--) exp_q.push_back(all_gain(8'(v)));
        exp_q.push_back(all_gain(8'h00));
        for (int i = 0; i < 5; i++) check_commit(0, "mute");
        mute = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back(with_band(all_gain(up_others[i]), 2, 8'(i + 1)));
        for (int i = 0; i < 6; i++) check_commit(0, "unmute");
    endtask

    task automatic test_handshake();
        bit ok;
        int stalled;
        wait_strobe(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hs_strobe: got no clk_enable expected one"); end
        @(negedge clk);
        drive_wr(0, 1'b1, 3'd5, 8'h10);
        stalled = 0;
        for (int i = 0; i < 30; i++) begin
            if (wif1.wr_ready === 1'b1) break;
            stalled++;
            @(negedge clk);
        end
        total++;
        if (stalled !== 9) begin bad++; $display("FAIL hs_ready_low: got %0d cycles expected 9", stalled); end
        total++;
        if (g1 !== exp_last[0]) begin bad++; $display("FAIL hs_no_early_effect: got %h expected %h", g1, exp_last[0]); end
        @(negedge clk);
        drive_wr(0, 1'b0, 3'd0, 8'h00);
        exp_q.push_back(with_band(exp_last[0], 5, 8'h05));
        check_commit(0, "hs_next_scan");
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        wait_strobe(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rms_strobe: got no clk_enable expected one"); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (g1 !== all_gain(8'h04)) begin bad++; $display("FAIL rms_gains1: got %h expected %h", g1, all_gain(8'h04)); end
        total++;
        if (g3 !== all_gain(8'h04)) begin bad++; $display("FAIL rms_gains3: got %h expected %h", g3, all_gain(8'h04)); end
        total++;
        if ({ce1, ae1, rb1, wif1.wr_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL rms_ctrl: got %b expected 0000", {ce1, ae1, rb1, wif1.wr_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            total++;
            if (ce1 !== (n == 64)) begin bad++; $display("FAIL rms_strobe_cycle_%0d: got %b expected %b", n, ce1, n == 64); end
        end
        repeat (10) @(negedge clk);
        total++;
        if (g1 !== all_gain(8'h04)) begin bad++; $display("FAIL rms_after_commit: got %h expected %h", g1, all_gain(8'h04)); end
        total++;
        if (rb1 !== 1'b0) begin bad++; $display("FAIL rms_busy: got %b expected 0", rb1); end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_clamp();
        test_mute();
        test_handshake();
        test_reset_mid_scan();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/equalizer_gain_scheduler.md
# equalizer_gain_scheduler

Control block for the 8-band equalizer: generates the sample-rate `clk_enable` strobe, holds per-band target gains written by a host, and ramps the live `amplifier_gains` bus toward those targets by a bounded step once per sample, to avoid zipper noise. All eight gains are committed to the equalizer atomically, so the datapath never sees a half-updated set. Sits between the host/config logic and the `equalizer` instance, driving its `clk_enable`, `amplifier_enable` and `amplifier_gains` inputs.

## Interface

- `NUMBER_OF_FILTERS`, 8: number of bands; band index width is 3.
- `GAIN_BITS`, 8: gain width, signed 8.2 two's complement.
- `SAMPLE_DIV`, 64: clk cycles per sample strobe; must be ≥ 12.
- `STEP`, 1: maximum gain change per sample, in LSBs (0.25 each); range 1..127.
- `DEFAULT_GAIN`, 4: reset value of every target/current/output gain (1.0).

- `clk`  in  1  system clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  level; enables the sample counter.
- `mute`  in  1  level; forces the effective target of every band to 0 (stored targets kept).
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  host write accept.
- `wr_band`  in  3  band index; 0 = lpf_1000hz … 7 = hpf_7000hz.
- `wr_gain`  in  GAIN_BITS  new signed target gain.
- `clk_enable`  out  1  one-cycle sample strobe to the equalizer.
- `amplifier_enable`  out  1  registered copy of `run`.
- `amplifier_gains`  out  NUMBER_OF_FILTERS*GAIN_BITS  packed live gains; band b at bits [(b+1)*8-1 : b*8].
- `ramp_busy`  out  1  high in SCAN or COMMIT.

## Operation

- Sample counter, 0..SAMPLE_DIV-1: increments while `run`=1 and wraps to 0; when `run`=0 it is held at 0. `clk_enable` is registered and asserted for the one cycle after the counter equals SAMPLE_DIV-1.
- Target file: 8 × GAIN_BITS. A write occurs when `wr_valid` and `wr_ready` are both 1 at a rising edge; it sets `target[wr_band]`. A later write to the same band overwrites the earlier one.
- `wr_ready` = 1 only in IDLE, so targets are frozen during a scan.
- Effective target: `eff[b]` = 0 if `mute`, else `target[b]`. `mute` is sampled per band as the band is scanned.
- Current-gain file: 8 × GAIN_BITS shadow registers, separate from `amplifier_gains`.
- FSM states:
  - IDLE: on a `clk_enable` cycle, go to SCAN with band index 0; otherwise stay.
  - SCAN: takes 8 cycles, one band per cycle (index 0→7). Compute `d = eff − cur` in GAIN_BITS+1 signed bits.
    - If |d| ≤ STEP, then `cur = eff`.
    - Else `cur = cur ± STEP`, moving toward `eff`.
    - Overflow is impossible because the result is bounded by `eff`.
    - After index 7, go to COMMIT.
  - COMMIT: takes 1 cycle. Copy all 8 `cur` values into `amplifier_gains` simultaneously, then go to IDLE.
- A scan runs on every strobe, even when all gains are settled. COMMIT then rewrites identical values.
- `run` deasserting mid-scan does not abort the scan; it completes and commits.

## Timing

- Reset (`rst_n`=0, asynchronous):
  - counter = 0; FSM = IDLE.
  - `clk_enable` = 0; `amplifier_enable` = 0; `ramp_busy` = 0; `wr_ready` = 0 while reset is asserted.
  - All targets, currents and `amplifier_gains` slices = DEFAULT_GAIN.
- `wr_ready` rises on the first clk edge after `rst_n` deasserts.
- `amplifier_enable` follows `run` with 1-cycle latency.
- Strobe timing: with `run` held high from cycle 0, `clk_enable` is high in cycles SAMPLE_DIV, 2·SAMPLE_DIV, and so on.
- Strobe to committed gains:
  - `ramp_busy` rises the cycle after `clk_enable`.
  - SCAN occupies 8 cycles, then COMMIT 1 cycle.
  - New `amplifier_gains` is visible 10 cycles after the `clk_enable` cycle; `ramp_busy` falls in the same cycle.
- Write to output: a write accepted before a strobe reaches the output at most STEP LSBs per sample. The number of samples to settle is ceil(|Δ|/STEP).
- Reset mid-scan: everything returns immediately to the reset values; no partial commit is visible.

## Test plan

- **Reset defaults.** Hold `rst_n`=0, then release with `run`=1.
  - Every gain slice = 0x04; `wr_ready`=1 one cycle after release.
  - `clk_enable` first high at cycle 64, then every 64 cycles.
- **Up-ramp, STEP=1.** Write band 3 = 0x08.
  - Band 3 output goes 5, 6, 7, 8 over four consecutive commits, then holds at 8.
  - Other bands stay at 4.
- **Large step and clamp.** STEP=3; write band 0 = −8 (0xF8) from 4.
  - Outputs: 1, −2, −5, −8, −8.
  - Verify signed arithmetic; no wrap to a positive value.
- **Mute and unmute.** STEP=1, all gains at 4; assert `mute`.
  - All bands step down 3, 2, 1, 0 and commit together on the same cycle.
  - Deassert `mute`: bands ramp back to their stored targets.
- **Handshake during scan.** Hold `wr_valid`=1 (band 5, 0x10) continuously across a strobe.
  - `wr_ready`=0 for exactly 9 cycles.
  - The write is accepted on the first IDLE cycle; the target takes effect at the next scan.
- **Reset mid-scan.** Pulse `rst_n` low during SCAN index 4.
  - All outputs return to reset values asynchronously.
  - No COMMIT occurs; the counter restarts from 0.
